// File: rtl/lbdr_param.sv
// LBDR routing unit: per-packet output-port selection from the header flit.
// Registers Rxy/Cx/cur_addr/Dr on reset, supports runtime Rxy/Cx reconfig.
//
// Ports:
//   clk, rst (sync, active-low)
//   empty, flit_type, dst_addr, rd     : input FIFO head and consume strobe
//   cur_addr_rst, Rxy_rst, Cx_rst,
//   Dr_rst                             : configuration captured during reset
//   cfg_we, cfg_Rxy, cfg_Cx            : runtime reconfiguration
//   Nport..Lport                       : registered one-hot port request
//   route_vld, route_err               : packet routed / packet unroutable
module lbdr_param #(
    parameter int         AXIS   = 4,
    parameter bit         DR_EN  = 1'b1,
    parameter logic [2:0] HEADER = 3'b001,
    parameter logic [2:0] TAIL   = 3'b100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            empty,
    input  logic [2:0]      flit_type,
    input  logic [AXIS-1:0] dst_addr,
    input  logic            rd,
    input  logic [AXIS-1:0] cur_addr_rst,
    input  logic [7:0]      Rxy_rst,
    input  logic [3:0]      Cx_rst,
    input  logic [1:0]      Dr_rst,
    input  logic            cfg_we,
    input  logic [7:0]      cfg_Rxy,
    input  logic [3:0]      cfg_Cx,
    output logic            Nport,
    output logic            Eport,
    output logic            Wport,
    output logic            Sport,
    output logic            Lport,
    output logic            route_vld,
    output logic            route_err
);

    // AXIS must be even: x = low half, y = high half.
    localparam int H = AXIS / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        ERR   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [AXIS-1:0] cur_q;
    logic [7:0]      rxy_q;
    logic [3:0]      cx_q;
    logic [1:0]      dr_q;
    logic            pend_q;
    logic [7:0]      pend_rxy;
    logic [3:0]      pend_cx;

    // Port vector order: {L,S,W,E,N}
    logic [4:0] ports_q, ports_n;
    logic       vld_q, vld_n;
    logic       err_q, err_n;

    logic [H-1:0] x_cur, y_cur, x_dst, y_dst;
    logic         n1, e1, w1, s1;
    logic         nm, em, wm, sm, loc;
    logic         rne, rnw, ren, res, rwn, rws, rse, rsw;
    logic         cn, ce, cw, cs;
    logic [4:0]   sel;
    logic         no_port;
    logic         is_hdr, is_tail_rd;

    assign x_cur = cur_q[H-1:0];
    assign y_cur = cur_q[AXIS-1:H];
    assign x_dst = dst_addr[H-1:0];
    assign y_dst = dst_addr[AXIS-1:H];

    assign n1 = y_dst < y_cur;
    assign s1 = y_cur < y_dst;
    assign e1 = x_cur < x_dst;
    assign w1 = x_dst < x_cur;

    assign {rsw, rse, rws, rwn, res, ren, rnw, rne} = rxy_q;
    assign {cs, cw, ce, cn} = cx_q;

    assign nm = ((n1 & ~e1 & ~w1) | (n1 & e1 & rne) | (n1 & w1 & rnw)) & cn;
    assign em = ((e1 & ~n1 & ~s1) | (e1 & n1 & ren) | (e1 & s1 & res)) & ce;
    assign wm = ((w1 & ~n1 & ~s1) | (w1 & n1 & rwn) | (w1 & s1 & rws)) & cw;
    assign sm = ((s1 & ~e1 & ~w1) | (s1 & e1 & rse) | (s1 & w1 & rsw)) & cs;
    assign loc = ~n1 & ~e1 & ~w1 & ~s1;

    // Single-port selection, N>E>W>S, then deroute via Dr.
    // Dr encoding equals the Cx bit index, so it also indexes sel[3:0].
    always_comb begin
        sel     = 5'b0;
        no_port = 1'b0;
        if (loc) begin
            sel[4] = 1'b1;
        end else if (nm) begin
            sel[0] = 1'b1;
        end else if (em) begin
            sel[1] = 1'b1;
        end else if (wm) begin
            sel[2] = 1'b1;
        end else if (sm) begin
            sel[3] = 1'b1;
        end else if (DR_EN && cx_q[dr_q]) begin
            sel[3:0] = 4'b0001 << dr_q;
        end else begin
            no_port = 1'b1;
        end
    end

    assign is_hdr     = ~empty & (flit_type == HEADER);
    assign is_tail_rd = ~empty & rd & (flit_type == TAIL);

    always_comb begin
        state_n = state;
        ports_n = ports_q;
        vld_n   = vld_q;
        err_n   = err_q;
        unique case (state)
            IDLE: begin
                ports_n = 5'b0;
                vld_n   = 1'b0;
                err_n   = 1'b0;
                if (is_hdr) begin
                    if (no_port) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end else begin
                        state_n = ROUTE;
                        ports_n = sel;
                        vld_n   = 1'b1;
                    end
                end
            end
            ROUTE, ERR: begin
                // Headers here are just payload; only a consumed tail ends it.
                if (is_tail_rd) begin
                    state_n = IDLE;
                    ports_n = 5'b0;
                    vld_n   = 1'b0;
                    err_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                ports_n = 5'b0;
                vld_n   = 1'b0;
                err_n   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ports_q  <= 5'b0;
            vld_q    <= 1'b0;
            err_q    <= 1'b0;
            cur_q    <= cur_addr_rst;
            rxy_q    <= Rxy_rst;
            cx_q     <= Cx_rst;
            dr_q     <= Dr_rst;
            pend_q   <= 1'b0;
            pend_rxy <= 8'b0;
            pend_cx  <= 4'b0;
        end else begin
            state   <= state_n;
            ports_q <= ports_n;
            vld_q   <= vld_n;
            err_q   <= err_n;
            if (state == IDLE) begin
                if (cfg_we) begin
                    rxy_q <= cfg_Rxy;
                    cx_q  <= cfg_Cx;
                end
            end else if (is_tail_rd) begin
                // IDLE-entry edge: a write on this very edge is the latest.
                pend_q <= 1'b0;
                if (cfg_we) begin
                    rxy_q <= cfg_Rxy;
                    cx_q  <= cfg_Cx;
                end else if (pend_q) begin
                    rxy_q <= pend_rxy;
                    cx_q  <= pend_cx;
                end
            end else if (cfg_we) begin
                pend_q   <= 1'b1;
                pend_rxy <= cfg_Rxy;
                pend_cx  <= cfg_Cx;
            end
        end
    end

    assign Nport     = ports_q[0];
    assign Eport     = ports_q[1];
    assign Wport     = ports_q[2];
    assign Sport     = ports_q[3];
    assign Lport     = ports_q[4];
    assign route_vld = vld_q;
    assign route_err = err_q;

endmodule

// File: tb/tb_lbdr_param.sv
// Bench for lbdr_param: table of single-packet vectors plus hand sequences.
// Two DUTs (deroute on / off) share stimulus; a queue holds expectations.
module tb_lbdr_param;

    localparam logic [2:0] HDR = 3'b001;
    localparam logic [2:0] BDY = 3'b010;
    localparam logic [2:0] TL  = 3'b100;

    // Packed {L,S,W,E,N,vld,err}
    localparam logic [6:0] EN = 7'b0000110;
    localparam logic [6:0] EE = 7'b0001010;
    localparam logic [6:0] EW = 7'b0010010;
    localparam logic [6:0] ES = 7'b0100010;
    localparam logic [6:0] EL = 7'b1000010;
    localparam logic [6:0] EZ = 7'b0000000;
    localparam logic [6:0] ER = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic       empty;
    logic [2:0] flit_type;
    logic [3:0] dst_addr;
    logic       rd;
    logic [3:0] cur_addr_rst;
    logic [7:0] Rxy_rst;
    logic [3:0] Cx_rst;
    logic [1:0] Dr_rst;
    logic       cfg_we;
    logic [7:0] cfg_Rxy;
    logic [3:0] cfg_Cx;

    logic n0, e0, w0, s0, l0, v0, r0;
    logic n1, e1, w1, s1, l1, v1, r1;
    logic [6:0] o0, o1;

    assign o0 = {l0, s0, w0, e0, n0, v0, r0};
    assign o1 = {l1, s1, w1, e1, n1, v1, r1};

    always #5 clk = ~clk;

    lbdr_param #(.AXIS(4), .DR_EN(1'b1)) u_dr (
        .clk(clk), .rst(rst), .empty(empty), .flit_type(flit_type),
        .dst_addr(dst_addr), .rd(rd), .cur_addr_rst(cur_addr_rst),
        .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .Dr_rst(Dr_rst),
        .cfg_we(cfg_we), .cfg_Rxy(cfg_Rxy), .cfg_Cx(cfg_Cx),
        .Nport(n0), .Eport(e0), .Wport(w0), .Sport(s0), .Lport(l0),
        .route_vld(v0), .route_err(r0)
    );

    lbdr_param #(.AXIS(4), .DR_EN(1'b0)) u_nodr (
        .clk(clk), .rst(rst), .empty(empty), .flit_type(flit_type),
        .dst_addr(dst_addr), .rd(rd), .cur_addr_rst(cur_addr_rst),
        .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .Dr_rst(Dr_rst),
        .cfg_we(cfg_we), .cfg_Rxy(cfg_Rxy), .cfg_Cx(cfg_Cx),
        .Nport(n1), .Eport(e1), .Wport(w1), .Sport(s1), .Lport(l1),
        .route_vld(v1), .route_err(r1)
    );

    typedef struct {
        logic [6:0] x0;
        logic [6:0] x1;
        string      nm;
    } exp_t;

    typedef struct {
        logic [3:0] cur;
        logic [7:0] rxy;
        logic [3:0] cx;
        logic [1:0] dr;
        logic [3:0] dst;
        logic [6:0] x0;
        logic [6:0] x1;
    } vec_t;

    exp_t sb[$];
    vec_t vt[16];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string nm, input int which,
                         input logic [6:0] act, input logic [6:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d: got %b want %b", nm, which, act, req);
    endtask

    // Push expectation, run one edge, pop and compare.
    task automatic cyc(input string nm, input logic [6:0] x0,
                       input logic [6:0] x1);
        exp_t e;
        e.x0 = x0;
        e.x1 = x1;
        e.nm = nm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check(e.nm, 0, o0, e.x0);
        check(e.nm, 1, o1, e.x1);
        cfg_we = 1'b0;
    endtask

    task automatic flit(input logic [2:0] t, input logic [3:0] d,
                        input logic em, input logic r, input string nm,
                        input logic [6:0] x0, input logic [6:0] x1);
        flit_type = t;
        dst_addr  = d;
        empty     = em;
        rd        = r;
        cyc(nm, x0, x1);
    endtask

    task automatic do_reset(input logic [3:0] cur, input logic [7:0] rxy,
                            input logic [3:0] cx, input logic [1:0] dr);
        rst          = 1'b0;
        cur_addr_rst = cur;
        Rxy_rst      = rxy;
        Cx_rst       = cx;
        Dr_rst       = dr;
        empty        = 1'b1;
        rd           = 1'b0;
        flit_type    = BDY;
        cyc("reset", EZ, EZ);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1; empty = 1'b1; flit_type = BDY; dst_addr = 4'h0;
        rd = 1'b0; cur_addr_rst = 4'h0; Rxy_rst = 8'h0; Cx_rst = 4'h0;
        Dr_rst = 2'b0; cfg_we = 1'b0; cfg_Rxy = 8'h0; cfg_Cx = 4'h0;

        vt[0]  = '{4'b0101, 8'h00, 4'hF, 2'd0, 4'b0110, EE, EE};
        vt[1]  = '{4'b0101, 8'h00, 4'hF, 2'd0, 4'b0101, EL, EL};
        vt[2]  = '{4'b0101, 8'h01, 4'hF, 2'd0, 4'b0010, EN, EN};
        vt[3]  = '{4'b0101, 8'h04, 4'hF, 2'd0, 4'b0010, EE, EE};
        vt[4]  = '{4'b0101, 8'h05, 4'hF, 2'd0, 4'b0010, EN, EN};
        vt[5]  = '{4'b0101, 8'h00, 4'hD, 2'd0, 4'b0110, EN, ER};
        vt[6]  = '{4'b0101, 8'h00, 4'hF, 2'd0, 4'b0001, EN, EN};
        vt[7]  = '{4'b0101, 8'h00, 4'hF, 2'd0, 4'b1101, ES, ES};
        vt[8]  = '{4'b0101, 8'h00, 4'hF, 2'd0, 4'b0100, EW, EW};
        vt[9]  = '{4'b0101, 8'h80, 4'hF, 2'd0, 4'b1100, ES, ES};
        vt[10] = '{4'b0101, 8'hA0, 4'hF, 2'd0, 4'b1100, EW, EW};
        vt[11] = '{4'b0101, 8'h00, 4'hF, 2'd1, 4'b0010, EE, ER};
        vt[12] = '{4'b0101, 8'h00, 4'hD, 2'd1, 4'b0110, ER, ER};
        vt[13] = '{4'b1010, 8'h40, 4'hF, 2'd0, 4'b1111, ES, ES};
        vt[14] = '{4'b1010, 8'h48, 4'hF, 2'd0, 4'b1111, EE, EE};
        vt[15] = '{4'b0011, 8'h00, 4'hF, 2'd3, 4'b0000, EW, EW};

        for (int i = 0; i < 16; i++) begin
            do_reset(vt[i].cur, vt[i].rxy, vt[i].cx, vt[i].dr);
            flit(HDR, vt[i].dst, 1'b0, 1'b1, $sformatf("v%0d_hdr", i),
                 vt[i].x0, vt[i].x1);
            flit(BDY, 4'h0, 1'b1, 1'b0, $sformatf("v%0d_hold", i),
                 vt[i].x0, vt[i].x1);
            flit(TL, 4'h0, 1'b0, 1'b1, $sformatf("v%0d_tail", i), EZ, EZ);
        end

        // Holding across empty toggles, stray header, unconsumed tail
        do_reset(4'b0101, 8'h00, 4'hF, 2'd0);
        flit(HDR, 4'b0110, 1'b0, 1'b1, "a_hdr", EE, EE);
        flit(BDY, 4'b0000, 1'b0, 1'b1, "a_body", EE, EE);
        flit(BDY, 4'b0000, 1'b1, 1'b0, "a_empty", EE, EE);
        flit(HDR, 4'b0101, 1'b0, 1'b1, "a_hdr_as_body", EE, EE);
        flit(TL, 4'b0000, 1'b0, 1'b0, "a_tail_nord", EE, EE);
        flit(TL, 4'b0000, 1'b1, 1'b1, "a_tail_empty", EE, EE);
        flit(TL, 4'b0000, 1'b0, 1'b1, "a_tail", EZ, EZ);
        flit(BDY, 4'b0110, 1'b0, 1'b1, "a_idle_body", EZ, EZ);
        flit(TL, 4'b0110, 1'b0, 1'b1, "a_idle_tail", EZ, EZ);
        flit(HDR, 4'b0110, 1'b1, 1'b0, "a_hdr_empty", EZ, EZ);

        // Pending cfg (last wins), applied at IDLE entry; back-to-back header
        flit(HDR, 4'b0110, 1'b0, 1'b1, "b_hdr", EE, EE);
        cfg_we = 1'b1; cfg_Rxy = 8'h00; cfg_Cx = 4'h0;
        flit(BDY, 4'b0000, 1'b0, 1'b1, "b_cfg1", EE, EE);
        cfg_we = 1'b1; cfg_Rxy = 8'h00; cfg_Cx = 4'hD;
        flit(BDY, 4'b0000, 1'b0, 1'b1, "b_cfg2", EE, EE);
        flit(TL, 4'b0000, 1'b0, 1'b1, "b_tail", EZ, EZ);
        flit(HDR, 4'b0110, 1'b0, 1'b1, "b_newcx", EN, ER);
        flit(TL, 4'b0000, 1'b0, 1'b1, "b_tail2", EZ, EZ);

        // cfg with header in IDLE: this header sees old Cx
        cfg_we = 1'b1; cfg_Rxy = 8'h00; cfg_Cx = 4'hF;
        flit(HDR, 4'b0110, 1'b0, 1'b1, "c_hdr_oldcx", EN, ER);
        flit(TL, 4'b0000, 1'b0, 1'b1, "c_tail", EZ, EZ);
        flit(HDR, 4'b0110, 1'b0, 1'b1, "c_hdr_newcx", EE, EE);
        flit(TL, 4'b0000, 1'b0, 1'b1, "c_tail2", EZ, EZ);

        // Reset mid-packet, then stray body ignored
        flit(HDR, 4'b0110, 1'b0, 1'b1, "d_hdr", EE, EE);
        do_reset(4'b0101, 8'h00, 4'hD, 2'd0);
        flit(BDY, 4'b0110, 1'b0, 1'b1, "d_body_ign", EZ, EZ);
        flit(TL, 4'b0110, 1'b0, 1'b1, "d_tail_ign", EZ, EZ);
        flit(HDR, 4'b0110, 1'b0, 1'b1, "d_hdr2", EN, ER);
        flit(TL, 4'b0000, 1'b0, 1'b1, "d_tail", EZ, EZ);

        if (sb.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard: %0d left, want 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/lbdr_param.md
LBDR_PARAM -- requirements
Module: lbdr_param

Interface
REQ-001 Parameter AXIS, default 4, total address width; x = low AXIS/2 bits, y = high AXIS/2 bits; SHALL be even.
REQ-002 Parameter DR_EN, default 1, enables the deroute fallback when 1.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous and active-low.
REQ-005 empty  in  1  input FIFO empty; the flit fields are valid only when empty=0.
REQ-006 flit_type  in  3  `HEADER/`BODY/`TAIL encodings from parameters.v.
REQ-007 dst_addr  in  AXIS  destination address of the current flit.
REQ-008 rd  in  1  flit consumed this cycle by the downstream crossbar.
REQ-009 cur_addr_rst  in  AXIS  router address, captured during reset.
REQ-010 Rxy_rst  in  8  routing bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne} (bit0=Rne), captured during reset.
REQ-011 Cx_rst  in  4  connectivity bits {Cs,Cw,Ce,Cn} (bit0=Cn), captured during reset.
REQ-012 Dr_rst  in  2  deroute port (00 N, 01 E, 10 W, 11 S), captured during reset.
REQ-013 cfg_we  in  1  runtime reconfiguration strobe.
REQ-014 cfg_Rxy  in  8 and cfg_Cx  in  4  runtime reconfiguration values.
REQ-015 Nport, Eport, Wport, Sport, Lport  out  1 each  registered one-hot output-port request.
REQ-016 route_vld  out  1  high while a packet route is held.
REQ-017 route_err  out  1  high while the current packet has no legal port.

Function
REQ-018 Comparators SHALL be unsigned on the AXIS/2-bit coordinates: N1=y_dst<y_cur, S1=y_cur<y_dst, E1=x_cur<x_dst, W1=x_dst<x_cur.
REQ-019 Minimal candidates SHALL be computed as follows.
- Nm=((N1&~E1&~W1)|(N1&E1&Rne)|(N1&W1&Rnw))&Cn
- Em=((E1&~N1&~S1)|(E1&N1&Ren)|(E1&S1&Res))&Ce
- Wm=((W1&~N1&~S1)|(W1&N1&Rwn)|(W1&S1&Rws))&Cw
- Sm=((S1&~E1&~W1)|(S1&E1&Rse)|(S1&W1&Rsw))&Cs
- Local=~N1&~E1&~W1&~S1
REQ-020 Forks are not supported; with more than one minimal candidate set, priority SHALL be N>E>W>S, and exactly one port SHALL be asserted.
REQ-021 Deroute rule: if Local=0, no minimal candidate is set, DR_EN=1 and the Cx bit of Dr is 1, the Dr port SHALL be selected.
REQ-022 Otherwise the block SHALL select no port and enter ERR.
REQ-023 FSM states SHALL be IDLE, ROUTE and ERR.
REQ-024 In IDLE, empty=0 with flit_type=`HEADER SHALL register the selected port, setting route_vld=1, and go to ROUTE (or to ERR with route_err=1), effective one cycle after the header is presented.
REQ-025 In IDLE, BODY and TAIL flits SHALL be ignored, and all outputs SHALL stay 0.
REQ-026 In ROUTE and ERR, the outputs SHALL hold regardless of empty; flit_type=`HEADER SHALL be treated as BODY.
REQ-027 In ROUTE or ERR, empty=0 & rd=1 & flit_type=`TAIL SHALL return the FSM to IDLE, and all outputs SHALL be 0 on the next cycle.
REQ-028 A new header SHALL be accepted no earlier than the cycle after IDLE is re-entered.
REQ-029 A cfg_we in IDLE SHALL load Rxy/Cx on that edge, so the new values apply to a header one cycle later.
REQ-030 A cfg_we outside IDLE SHALL be captured as pending (the last write wins) and applied on the IDLE-entry edge.
REQ-031 When cfg_we coincides with a header in IDLE, routing SHALL use the old values.
REQ-032 The port outputs SHALL always be one-hot or all-zero.

Reset
REQ-033 While rst=0 at a clock edge, the block SHALL load Rxy, Cx, cur_addr and Dr from the *_rst inputs and clear any pending cfg.
REQ-034 While rst=0 at a clock edge, state SHALL go to IDLE and all port outputs, route_vld and route_err SHALL be 0.
REQ-035 Reset mid-packet SHALL abort the packet with no residual state.

Verification
REQ-036 Reset with cur_addr_rst=4'b0101, Cx=1111 and a header with dst=4'b0110 -> Eport=1 and route_vld=1 next cycle; both hold over a body with empty toggling; after tail+rd, everything is 0 next cycle.
REQ-037 Header with dst=4'b0101 -> Lport=1 only.
REQ-038 Header with dst=4'b0010 (N1, E1 set) -> Rne=1, Ren=0 gives Nport; Rne=0, Ren=1 gives Eport; both set gives Nport.
REQ-039 Cx=1101 and dst=4'b0110 -> with Dr=00, Nport=1 (deroute); with DR_EN=0, route_err=1 and no port until tail+rd.
REQ-040 cfg_we with Cx=1101 during ROUTE -> the current packet is unaffected; the next header to dst=4'b0110 uses the new Cx.
REQ-041 rst=0 in ROUTE -> all outputs 0 after the next edge; a BODY flit after reset is ignored.
